fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the SimpleRISC pipeline. It owns the program counter, issues word fetches to instruction memory over a valid/ready request and valid-only response interface, and presents one instruction per cycle to the operand-fetch/decode stage, where `inst_out` feeds the control decoder directly. It handles backpressure from decode and flushes on taken-branch redirects from the branch unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `ADDR_W`, default 32: PC and address width.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  a fetch request is presented.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_addr`  out  ADDR_W  byte address of the fetch, always 4-aligned.
- `imem_rsp_valid`  in  1  response data is valid; exactly one response per accepted request, arriving one or more cycles after acceptance.
- `imem_rsp_data`  in  32  fetched instruction word.
- `branch_taken`  in  1  redirect request from the branch unit.
- `branch_pc`  in  ADDR_W  redirect target; bits [1:0] ignored and treated as 0.
- `of_ready`  in  1  decode stage consumes `inst_out` this cycle.
- `inst_valid`  out  1  `inst_out`/`pc_out` hold a valid instruction.
- `inst_out`  out  32  instruction word, with opcode in [31:27] and the immediate flag in [26].
- `pc_out`  out  ADDR_W  address of `inst_out`.

## Operation
- State: `pc`, `req_pc`, 1-entry `hold` buffer with its valid bit, `discard` flag, output register.
- FSM states:
  - REQ: drives `imem_req_valid`=1 with `imem_addr`=`pc`. On `imem_req_ready`, it latches `req_pc`=`pc` and moves to WAIT.
  - WAIT: waits for `imem_rsp_valid`.
    - If `discard`=1, it drops the response, clears `discard`, and moves to REQ.
    - If the output register is free (`inst_valid`=0 or `of_ready`=1), it loads `inst_out`/`pc_out` from the response and `req_pc`, sets `pc`=`req_pc`+4, and moves to REQ.
    - Otherwise it writes the response into `hold`, sets `pc`=`req_pc`+4, and moves to HOLD.
  - HOLD: when `of_ready`=1, it moves `hold` into the output register and moves to REQ. No request is issued in HOLD.
- Output register: `inst_valid` clears when `of_ready`=1 and no new instruction is loaded in the same cycle.
- Redirect (`branch_taken`=1) has the highest priority in every state:
  - Sets `pc`=`branch_pc`, clears `inst_valid` and `hold`, and ignores `of_ready`.
  - In REQ with no handshake this cycle: stays in REQ, and the next request uses the new `pc`.
  - In REQ with a handshake this cycle: the wrong-path request is outstanding, so it moves to WAIT with `discard`=1.
  - In WAIT with `imem_rsp_valid`=1 this cycle: drops the response and moves to REQ.
  - In WAIT with no response this cycle: sets `discard`=1 and stays in WAIT.
  - In HOLD: moves to REQ.
- Arithmetic: PC increment is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- At most one request is outstanding at any time.

## Timing
- Reset values (async assert):
  - `pc`=`RESET_PC`; state REQ; `discard`=0; `hold` empty.
  - `inst_valid`=0, `inst_out`=0, `pc_out`=0.
  - `imem_req_valid` is 0 while `rst_n`=0 and is asserted the first cycle after deassertion.
- Latency: request accepted in cycle N, response in N+k (k≥1), `inst_valid` high in cycle N+k+1.
- Throughput: one instruction per 2 cycles with k=1. The next request is issued the cycle after the response.
- Redirect takes effect on the clock edge where `branch_taken` is sampled. The first target-path request is presented the next cycle, or after the discarded response arrives.
- Reset asserted mid-transaction returns the block to the reset state. The memory side is also reset, so no stale response is tracked.
- `imem_req_valid`, once asserted, stays high with a stable `imem_addr` until `imem_req_ready` or a redirect.

## Structure
- Shared package `simplerisc_pkg`:
  - `INST_W`=32 and `RESET_PC`.
  - Opcode constants for the branch, call and ret opcodes (10000, 10001, 10010, 10011, 10100).
  - The `fetch_state_t` enum {REQ, WAIT, HOLD}.
- Single module; no sub-module needed. The hold buffer is inline.

## Test plan
- Reset then free-running memory (k=1, always ready, data = address): `inst_out` sequence 0,4,8,… with `pc_out` equal to the data; `inst_valid` first high in the 3rd cycle after `rst_n` rises.
- `of_ready`=0 for 5 cycles mid-stream: one instruction in the output register plus one in `hold`; no request issued; after release, both are delivered in order with no gap or duplicate.
- `branch_taken` with `branch_pc`=32'h100 in the same cycle as a request handshake: the late response is discarded; the next `pc_out` is 32'h100.
- Redirect in WAIT coinciding with `imem_rsp_valid`: the response is dropped; a request for the target is presented the next cycle; `inst_valid`=0 meanwhile.
- Redirect to 32'hFFFF_FFFC: delivers `pc_out` FFFF_FFFC then 0000_0000.
- `rst_n` pulsed low while in WAIT: all outputs are at their reset values immediately; the first post-reset request uses `RESET_PC`.

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions used by the fetch stage and its bench.
//   INST_W        instruction word width
//   RESET_PC      default program counter after reset
//   OP_*          control-flow opcodes (inst[31:27]) seen by the decoder
//   fetch_state_t fetch sequencer states
package simplerisc_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//   imem_req_valid / imem_req_ready : request handshake, transfer when both high
//                                     at a rising edge; valid never drops and
//                                     addr never changes while waiting for ready
//                                     (a redirect is the only exception)
//   imem_addr                       : 4-aligned byte address of the request
//   imem_rsp_valid / imem_rsp_data  : valid-only response, one per accepted
//                                     request, one or more cycles later
interface fetch_unit_if #(
    parameter int ADDR_W = 32
);
    import simplerisc_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_unit.sv
// SimpleRISC instruction-fetch stage. Owns the PC, keeps at most one fetch
// outstanding on the imem bus and presents one instruction at a time to decode.
//   clk, rst_n         clock, asynchronous active-low reset
//   imem               instruction-memory bus (master side)
//   branch_taken/_pc   redirect from the branch unit, overrides everything
//   of_ready           decode consumes inst_out this cycle
//   inst_valid/inst_out/pc_out  registered instruction presented to decode
//   dbg_state_o        current sequencer state
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(simplerisc_pkg::RESET_PC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fetch_unit_if.master                imem,
    input  logic                        branch_taken,
    input  logic [ADDR_W-1:0]           branch_pc,
    input  logic                        of_ready,
    output logic                        inst_valid,
    output logic [31:0]                 inst_out,
    output logic [ADDR_W-1:0]           pc_out,
    output simplerisc_pkg::fetch_state_t dbg_state_o
);
    import simplerisc_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              discard_q, discard_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              req_valid_q, req_valid_d;

    logic              fire;
    logic              out_free;
    logic [ADDR_W-1:0] target_pc;
    logic              unused_pc_bits;

    assign fire           = req_valid_q & imem.imem_req_ready;
    assign out_free       = ~inst_valid_q | of_ready;
    assign target_pc      = {branch_pc[ADDR_W-1:2], 2'b00};
    assign unused_pc_bits = &{1'b0, branch_pc[1:0]};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        discard_d    = discard_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        pc_out_d     = pc_out_q;

        // Consumption by decode; overridden below if something new is loaded.
        if (of_ready) begin
            inst_valid_d = 1'b0;
        end

        if (branch_taken) begin
            pc_d         = target_pc;
            inst_valid_d = 1'b0;
            hold_valid_d = 1'b0;
            unique case (state_q)
                REQ: begin
                    // A request accepted this edge is wrong-path and must be dropped.
                    if (fire) begin
                        state_d   = WAIT;
                        discard_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        state_d   = REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                HOLD:    state_d = REQ;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (fire) begin
                        req_pc_d = pc_q;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = REQ;
                        end else if (out_free) begin
                            inst_d       = imem.imem_rsp_data;
                            pc_out_d     = req_pc_q;
                            inst_valid_d = 1'b1;
                            pc_d         = req_pc_q + ADDR_W'(4);
                            state_d      = REQ;
                        end else begin
                            hold_d       = imem.imem_rsp_data;
                            hold_valid_d = 1'b1;
                            pc_d         = req_pc_q + ADDR_W'(4);
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // req_pc_q still names the held word: no request is issued in HOLD.
                    if (of_ready && hold_valid_q) begin
                        inst_d       = hold_q;
                        pc_out_d     = req_pc_q;
                        inst_valid_d = 1'b1;
                        hold_valid_d = 1'b0;
                        state_d      = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end

        // Registered request valid: low in reset, high the cycle after release.
        req_valid_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            discard_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            pc_out_q     <= '0;
            req_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            discard_q    <= discard_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pc_out_q     <= pc_out_d;
            req_valid_q  <= req_valid_d;
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_addr      = pc_q;
    assign inst_valid          = inst_valid_q;
    assign inst_out            = inst_q;
    assign pc_out              = pc_out_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset
// sequences and a randomized run against a stream-level reference model.
module tb_fetch_unit;
    import simplerisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic        of_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    fetch_state_t dbg_state;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32)) imem_bus ();

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_bus),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .of_ready     (of_ready),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .dbg_state_o  (dbg_state)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: the delivered stream is consecutive words from exp_pc,
    // restarting at the (aligned) target on each redirect.
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_q[$];
    int          n_consumed = 0;

    // Memory model: one response per accepted request, k cycles later.
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] salt = 32'h0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    // One clock: drive inputs, observe the edge, then update the models.
    task automatic cycle(input bit rdy, input bit ofr, input bit br,
                         input logic [31:0] bpc, input int k);
        bit          hs, cons, rsp;
        logic [31:0] a_snap, pc_snap, inst_snap;
        imem_bus.imem_req_ready = rdy;
        of_ready     = ofr;
        branch_taken = br;
        branch_pc    = bpc;
        rsp = mem_busy && (mem_cnt == 0);
        imem_bus.imem_rsp_valid = rsp;
        imem_bus.imem_rsp_data  = rsp ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        hs        = imem_bus.imem_req_valid && rdy;
        cons      = inst_valid && ofr && !br;
        a_snap    = imem_bus.imem_addr;
        pc_snap   = pc_out;
        inst_snap = inst_out;
        if (prev_stall) begin
            check("req_stays_valid", 32'(imem_bus.imem_req_valid), 32'd1);
            check("req_addr_stable", a_snap, prev_addr);
        end
        prev_stall = imem_bus.imem_req_valid && !rdy && !br;
        prev_addr  = a_snap;
        @(posedge clk);
        #1;
        if (cons) begin
            check("deliver_pc", pc_snap, exp_pc);
            check("deliver_inst", inst_snap, mem_word(exp_pc));
            if (exp_q.size() > 0) check("seq_pc", pc_snap, exp_q.pop_front());
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
        end
        if (br) exp_pc = {bpc[31:2], 2'b00};
        if (rsp) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (hs) begin
            check("one_outstanding", 32'(mem_busy), 32'd0);
            check("addr_aligned", {30'd0, a_snap[1:0]}, 32'd0);
            mem_busy = 1'b1;
            mem_cnt  = k - 1;
            mem_addr = a_snap;
        end
    endtask

    typedef struct {
        bit          rdy;
        bit          ofr;
        bit          exp_rv;
        bit          exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[17];

    initial begin
        bit          got;
        int          base;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0;

        // Cycles 1..8: free-running memory; 9..17: decode stalls for 5 edges.
        vecs[0]  = '{1, 1, 1, 0, 32'h0};
        vecs[1]  = '{1, 1, 0, 0, 32'h0};
        vecs[2]  = '{1, 1, 1, 1, 32'h0};
        vecs[3]  = '{1, 1, 0, 0, 32'h0};
        vecs[4]  = '{1, 1, 1, 1, 32'h4};
        vecs[5]  = '{1, 1, 0, 0, 32'h4};
        vecs[6]  = '{1, 1, 1, 1, 32'h8};
        vecs[7]  = '{1, 1, 0, 0, 32'h8};
        vecs[8]  = '{1, 1, 1, 1, 32'hC};
        vecs[9]  = '{1, 0, 0, 1, 32'hC};
        vecs[10] = '{1, 0, 0, 1, 32'hC};
        vecs[11] = '{1, 0, 0, 1, 32'hC};
        vecs[12] = '{1, 0, 0, 1, 32'hC};
        vecs[13] = '{1, 0, 0, 1, 32'hC};
        vecs[14] = '{1, 1, 1, 1, 32'h10};
        vecs[15] = '{1, 1, 0, 0, 32'h10};
        vecs[16] = '{1, 1, 1, 1, 32'h14};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(REQ));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].rdy, vecs[i].ofr, 1'b0, 32'h0, 1);
            check($sformatf("vec%0d_req_valid", i + 1), 32'(imem_bus.imem_req_valid), 32'(vecs[i].exp_rv));
            check($sformatf("vec%0d_inst_valid", i + 1), 32'(inst_valid), 32'(vecs[i].exp_iv));
            check($sformatf("vec%0d_pc_out", i + 1), pc_out, vecs[i].exp_pc);
            check($sformatf("vec%0d_inst_out", i + 1), inst_out, vecs[i].exp_pc);
        end

        // Redirect coinciding with a request handshake; late response dropped.
        cycle(1'b1, 1'b1, 1'b1, 32'h100, 3);
        check("br_hs_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        check("br_hs_inst_valid", 32'(inst_valid), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
            got = inst_valid;
        end
        check("br_hs_arrived", 32'(got), 32'd1);
        check("br_hs_pc_out", pc_out, 32'h100);

        // Redirect in WAIT on the very cycle the response arrives.
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
            got = mem_busy && (mem_cnt == 0);
        end
        check("br_rsp_setup", 32'(got), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 32'h200, 1);
        check("br_rsp_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
        check("br_rsp_addr", imem_bus.imem_addr, 32'h200);
        check("br_rsp_inst_valid", 32'(inst_valid), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
            got = inst_valid;
        end
        check("br_rsp_arrived", 32'(got), 32'd1);
        check("br_rsp_pc_out", pc_out, 32'h200);

        // Redirect near the top of memory; low target bits must be ignored.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1);
        check("wrap_done", 32'(exp_q.size()), 32'd0);

        // Reset pulsed while a fetch is outstanding.
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 3);
            got = mem_busy;
        end
        check("rst_wait_setup", 32'(got), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        check("midrst_inst_valid", 32'(inst_valid), 32'd0);
        check("midrst_inst_out", inst_out, 32'd0);
        check("midrst_pc_out", pc_out, 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(REQ));
        mem_busy   = 1'b0;
        prev_stall = 1'b0;
        exp_pc     = 32'h0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1);
            got = mem_busy;
        end
        check("postrst_req_seen", 32'(got), 32'd1);
        check("postrst_req_addr", mem_addr, 32'h0);

        // Randomized traffic against the stream model.
        salt = $urandom;
        base = n_consumed;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 4, $urandom, $urandom_range(1, 4));
        end
        check("random_progress", 32'(n_consumed > base + 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
